fcmp_pipe: RTL and testbench
============================

FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, mantissa field width; operand width W = 1+EXP_W+MAN_W.
REQ-003 Parameter STAGES, default 2, pipeline depth, legal values 1..4.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rstn  input  1  reset, asynchronous and active-low.
REQ-006 Port in_valid  input  1  request present.
REQ-007 Port in_ready  output  1  request accepted this cycle if in_valid is high.
REQ-008 Port op  input  3  operation: 000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others reserved.
REQ-009 Port x  input  W  operand x, {sign, exp, man}.
REQ-010 Port y  input  W  operand y.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts result.
REQ-013 Port res  output  W  result.
REQ-014 Port nv  output  1  invalid-operation flag, qualified by out_valid.

Function
REQ-015 FEQ/FLT/FLE: res = {(W-1)'b0, bit}, bit = (x==y), (x<y), (x<=y) by IEEE ordering.
REQ-016 FMIN/FMAX: res = lesser/greater operand, bit-exact copy of the chosen input.
REQ-017 Ordering: sign first, then exponent, then mantissa; for both negative, magnitude order inverts.
REQ-018 +0 and -0 compare equal in all ops; FMIN(+0,-0) and FMIN(-0,+0) = -0; FMAX of the same pairs = +0.
REQ-019 Reserved op: res = 0, nv = 0, handshake unchanged.
REQ-020 Latency: result appears on out_valid exactly STAGES cycles after acceptance when no stall.
REQ-021 Each stage holds one valid bit; a stage loads when it is empty or its contents advance in the same cycle.
REQ-022 in_ready = stage-1 empty OR stage-1 advancing; combinational from out_ready, no extra bubble.
REQ-023 Throughput: one result per cycle while in_valid and out_ready stay high.
REQ-024 Stall: out_valid high with out_ready low holds res, nv and all stage contents stable.
REQ-025 Results leave in acceptance order; no request is dropped or duplicated.
REQ-026 Simultaneous accept and retire when full: both occur in the same cycle, occupancy unchanged.
REQ-027 Magnitude compare uses a single (EXP_W+MAN_W+1)-bit subtraction of {exp,man} fields; borrow gives less-than and a zero difference gives equal.

Reset
REQ-028 rstn low clears all stage valid bits immediately, without waiting for a clock edge: out_valid = 0, res = 0, nv = 0.
REQ-029 in_ready is 1 during and after reset.
REQ-030 Reset mid-operation discards in-flight requests; the first post-reset accept behaves as from idle.

Configuration
REQ-031 Macro FCMP_NAN_EN: when defined, NaN (exp all ones, man non-zero) is detected.
REQ-032 With FCMP_NAN_EN: FEQ/FLT/FLE with any NaN give bit = 0; FLT/FLE with any NaN, or any op with a signalling NaN (man MSB = 0), set nv = 1.
REQ-033 With FCMP_NAN_EN: FMIN/FMAX return the non-NaN operand, or canonical qNaN {0, all-ones exp, 1, zeros} if both are NaN; nv = 1 only if a signalling NaN is present.
REQ-034 Without FCMP_NAN_EN: NaN is ordered as an ordinary bit pattern by REQ-017, and nv is tied to 0.

Verification (defaults, STAGES=2)
REQ-035 FLT x=0x3F800000 y=0x40000000 -> res=0x00000001, nv=0, out_valid 2 cycles after accept.
REQ-036 FLE x=0xBF800000 y=0xC0000000 -> res=0; FMAX of the same pair -> res=0xBF800000.
REQ-037 FEQ x=0x80000000 y=0x00000000 -> res=1; FMIN -> 0x80000000; FMAX -> 0x00000000.
REQ-038 FCMP_NAN_EN, FLT x=0x7FC00000 y=0x3F800000 -> res=0, nv=1; FMIN -> 0x3F800000, nv=0; FMIN x=0x7F800001 y=0x3F800000 -> 0x3F800000, nv=1; without the macro FLT -> res=0, nv=0.
REQ-039 Stream 8 back-to-back FLT ops with out_ready low in cycles 3-5 -> in_ready low once full; 8 ordered results, none lost; res stable while stalled.
REQ-040 rstn pulsed low with 2 requests in flight -> out_valid=0 at once; no stale result after release; next request has normal latency.

Source files
------------

// File: rtl/fcmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fcmp_pipe
// Description : Pipelined IEEE-style floating-point compare / min / max unit.
//               The result is computed combinationally from the accepted
//               operands and carried through STAGES registered stages with a
//               valid/ready handshake. Stages fill up behind a stalled output.
//
//   Parameters
//     EXP_W   exponent field width
//     MAN_W   mantissa field width (operand width W = 1+EXP_W+MAN_W)
//     STAGES  pipeline depth, 1..4
//
//   Ports
//     clk        rising-edge clock
//     rstn       asynchronous active-low reset
//     in_valid   request present
//     in_ready   request accepted this cycle if in_valid is high
//     op         000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others reserved
//     x, y       operands {sign, exp, man}
//     out_valid  result present
//     out_ready  consumer accepts result
//     res        result (compare bit in LSB, or selected operand)
//     nv         invalid-operation flag, qualified by out_valid
//
//   Build option
//     FCMP_NAN_EN  when defined, NaN operands follow unordered semantics and
//                  raise nv. When undefined, NaNs are ordinary bit patterns.
//
// Revision    : 1.0  initial release
// ============================================================================
module fcmp_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             op,
    input  logic [EXP_W+MAN_W:0]   x,
    input  logic [EXP_W+MAN_W:0]   y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   res,
    output logic                   nv
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam int M = EXP_W + MAN_W;

    localparam logic [2:0] c_OP_FEQ  = 3'b000;
    localparam logic [2:0] c_OP_FLT  = 3'b001;
    localparam logic [2:0] c_OP_FLE  = 3'b010;
    localparam logic [2:0] c_OP_FMIN = 3'b011;
    localparam logic [2:0] c_OP_FMAX = 3'b100;

    // Canonical quiet NaN: positive, all-ones exponent, mantissa MSB set.
    localparam logic [W-1:0] c_QNAN =
        {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));

    // ------------------------------------------------------------------------
    // Ordering
    // ------------------------------------------------------------------------
    logic          w_sx;
    logic          w_sy;
    logic [M-1:0]  w_xm;
    logic [M-1:0]  w_ym;
    logic [M:0]    w_diff;
    logic          w_mag_lt;
    logic          w_mag_eq;
    logic          w_zero_both;
    logic          w_lt;
    logic          w_eq;
    logic [W-1:0]  w_min;
    logic [W-1:0]  w_max;

    assign w_sx = x[W-1];
    assign w_sy = y[W-1];
    assign w_xm = x[M-1:0];
    assign w_ym = y[M-1:0];

    // One subtraction of the {exp,man} magnitudes: the borrow out of the
    // extended MSB means |x| < |y|, an all-zero difference means |x| == |y|.
    assign w_diff      = {1'b0, w_xm} - {1'b0, w_ym};
    assign w_mag_lt    = w_diff[M];
    assign w_mag_eq    = (w_diff[M-1:0] == '0);
    assign w_zero_both = (w_xm == '0) && (w_ym == '0);

    always_comb begin
        w_lt = 1'b0;
        w_eq = 1'b0;
        if (w_zero_both) begin
            // +0 and -0 are the same value regardless of sign bits.
            w_eq = 1'b1;
        end else if (w_sx != w_sy) begin
            w_lt = w_sx;
        end else if (!w_sx) begin
            w_lt = w_mag_lt;
            w_eq = w_mag_eq;
        end else begin
            // Both negative: the larger magnitude is the smaller value.
            w_lt = !w_mag_lt && !w_mag_eq;
            w_eq = w_mag_eq;
        end
    end

    // For a pair of zeros min prefers the negative one and max the positive
    // one. Equal non-zero operands are bit-identical, so either pick is fine.
    assign w_min = w_zero_both ? (w_sx ? x : y) : (w_lt ? x : y);
    assign w_max = w_zero_both ? (w_sx ? y : x) : (w_lt ? y : x);

    // ------------------------------------------------------------------------
    // NaN classification
    // ------------------------------------------------------------------------
    logic w_xnan;
    logic w_ynan;
    logic w_xsnan;
    logic w_ysnan;
    logic w_anynan;
    logic w_anysnan;

`ifdef FCMP_NAN_EN
    assign w_xnan  = (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
    assign w_ynan  = (&y[W-2:MAN_W]) && (|y[MAN_W-1:0]);
    assign w_xsnan = w_xnan && !x[MAN_W-1];
    assign w_ysnan = w_ynan && !y[MAN_W-1];
`else
    assign w_xnan  = 1'b0;
    assign w_ynan  = 1'b0;
    assign w_xsnan = 1'b0;
    assign w_ysnan = 1'b0;
`endif

    assign w_anynan  = w_xnan || w_ynan;
    assign w_anysnan = w_xsnan || w_ysnan;

    // ------------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------------
    logic [W-1:0] w_res;
    logic         w_nv;

    always_comb begin
        w_res = '0;
        w_nv  = 1'b0;
        case (op)
            c_OP_FEQ: begin
                w_res[0] = w_eq && !w_anynan;
                w_nv     = w_anysnan;
            end
            c_OP_FLT: begin
                w_res[0] = w_lt && !w_anynan;
                w_nv     = w_anynan;
            end
            c_OP_FLE: begin
                w_res[0] = (w_lt || w_eq) && !w_anynan;
                w_nv     = w_anynan;
            end
            c_OP_FMIN, c_OP_FMAX: begin
                if (w_xnan && w_ynan) begin
                    w_res = c_QNAN;
                end else if (w_xnan) begin
                    w_res = y;
                end else if (w_ynan) begin
                    w_res = x;
                end else begin
                    w_res = (op == c_OP_FMIN) ? w_min : w_max;
                end
                w_nv = w_anysnan;
            end
            default: begin
                w_res = '0;
                w_nv  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pipeline with per-stage valid bits
    // ------------------------------------------------------------------------
    logic [STAGES-1:0] r_vld;
    logic [W-1:0]      r_res [STAGES];
    logic [STAGES-1:0] r_nv;
    logic [STAGES-1:0] w_load;
    logic              w_chain;

    // A stage may load when it is empty or its contents move on this cycle;
    // the "moves on" term ripples back from out_ready through the stages.
    always_comb begin
        w_load  = '0;
        w_chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_load[i] = !r_vld[i] || w_chain;
            w_chain   = w_load[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_nv  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= in_valid;
                r_res[0] <= w_res;
                r_nv[0]  <= w_nv;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    r_res[i] <= r_res[i-1];
                    r_nv[i]  <= r_nv[i-1];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_vld[STAGES-1];
    assign res       = r_res[STAGES-1];
    assign nv        = r_nv[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_fcmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fcmp_pipe
// Description : Scoreboard bench for fcmp_pipe (default parameters, 32-bit
//               operands). Expected responses are queued at acceptance and
//               popped by an independent monitor when a result retires.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fcmp_pipe;

    localparam int STAGES = 2;

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op        = 3'b000;
    logic [31:0] x         = '0;
    logic [31:0] y         = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] res;
    logic        nv;

    fcmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .nv        (nv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] r;
        logic        f;
        bit          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_out = 0;

    // ---------------- reference model ----------------
    // Values are mapped onto a signed integer line: +mag for positive, -mag
    // for negative, so both zeros land on 0 and plain integer compare gives
    // the IEEE total order for non-NaN operands.
    function automatic longint key(input logic [31:0] v);
        longint m;
        m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    function automatic bit is_nan(input logic [31:0] v);
`ifdef FCMP_NAN_EN
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_snan(input logic [31:0] v);
        return is_nan(v) && !v[22];
    endfunction

    function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r, output logic f);
        longint ka, kb;
        bit an, bn, sn;
        ka = key(a);
        kb = key(b);
        an = is_nan(a);
        bn = is_nan(b);
        sn = is_snan(a) || is_snan(b);
        r  = '0;
        f  = 1'b0;
        case (o)
            3'd0: begin r[0] = (ka == kb) && !(an || bn); f = sn; end
            3'd1: begin r[0] = (ka <  kb) && !(an || bn); f = an || bn; end
            3'd2: begin r[0] = (ka <= kb) && !(an || bn); f = an || bn; end
            3'd3, 3'd4: begin
                if (an && bn)      r = 32'h7FC00000;
                else if (an)       r = b;
                else if (bn)       r = a;
                else if (ka < kb)  r = (o == 3'd3) ? a : b;
                else if (kb < ka)  r = (o == 3'd3) ? b : a;
                else if (o == 3'd3) r = a[31] ? a : b;
                else               r = a[31] ? b : a;
                f = sn;
            end
            default: begin r = '0; f = 1'b0; end
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // One driver cycle: inputs change at the falling edge, acceptance is
    // judged just after, well before the next rising edge.
    task automatic drive(input bit v, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit ordy,
                         input logic [31:0] er, input logic ef, input bit lat,
                         output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        op        = o;
        x         = a;
        y         = b;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.r = er; e.f = ef; e.lat = lat; e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ef, input bit lat, input bit ordy);
        bit acc;
        int t;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 100) begin
            drive(1'b1, o, a, b, ordy, er, ef, lat, acc);
            t++;
        end
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low, op %0d", o);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, '0, '0, 1'b1, '0, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            idle(1);
            t++;
        end
        chk("drain_queue_empty", 32'(sbq.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 11))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'h3F800000;
            3:       return 32'hBF800000;
            4:       return 32'h7F800000;
            5:       return 32'hFF800000;
            6:       return 32'h7FC00000;
            7:       return 32'h7F800001;
            8:       return 32'hFFC00000;
            9:       return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        bit          stalled;
        logic [31:0] p_res;
        logic        p_nv;
        exp_t        e;
        stalled = 1'b0;
        p_res   = '0;
        p_nv    = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid_held", 32'(out_valid), 32'd1);
                    chk("stall_res_held", res, p_res);
                    chk("stall_nv_held", 32'(nv), 32'(p_nv));
                end
                if (out_valid && sbq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_output: res %h with empty scoreboard", res);
                end else if (out_valid && out_ready) begin
                    e = sbq.pop_front();
                    n_out++;
                    chk("res", res, e.r);
                    chk("nv", 32'(nv), 32'(e.f));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(STAGES));
                end
                stalled = out_valid && !out_ready;
                p_res   = res;
                p_nv    = nv;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        bit          acc;
        bit          saw_block;
        int          k, i, base;
        logic [31:0] a, b, er;
        logic [2:0]  o;
        logic        ef;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_res", res, 32'd0);
        chk("reset_nv", 32'(nv), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        #2 rstn = 1'b1;
        idle(2);

        // Directed vectors with explicit expectations and latency checks
        send(3'd1, 32'h3F800000, 32'h40000000, 32'h00000001, 1'b0, 1'b1, 1'b1);
        send(3'd2, 32'hBF800000, 32'hC0000000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send(3'd4, 32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0, 1'b1, 1'b1);
        send(3'd0, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b1);
        send(3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b1);
        send(3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send(3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b1);
        send(3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send(3'd2, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 1'b1);
        send(3'd6, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send(3'd3, 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0, 1'b1, 1'b1);
`ifdef FCMP_NAN_EN
        send(3'd1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1, 1'b1, 1'b1);
        send(3'd3, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 1'b1);
        send(3'd3, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1, 1'b1, 1'b1);
        send(3'd4, 32'h7FC00000, 32'hFFC00000, 32'h7FC00000, 1'b0, 1'b1, 1'b1);
        send(3'd0, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send(3'd0, 32'h7F800001, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b1);
`else
        send(3'd1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0, 1'b1, 1'b1);
        send(3'd3, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 1'b1);
        send(3'd0, 32'h7FC00000, 32'h7FC00000, 32'h00000001, 1'b0, 1'b1, 1'b1);
`endif
        drain();

        // Eight back-to-back FLT ops, consumer stalls in cycles 3..5
        saw_block = 1'b0;
        base = n_out;
        k = 0;
        i = 0;
        while (i < 8 && k < 100) begin
            a = rand_val();
            b = rand_val();
            model(3'd1, a, b, er, ef);
            drive(1'b1, 3'd1, a, b, !(k >= 3 && k <= 5), er, ef, 1'b0, acc);
            if (!in_ready) saw_block = 1'b1;
            if (acc) i++;
            k++;
        end
        drain();
        chk("stream_in_ready_dropped", 32'(saw_block), 32'd1);
        chk("stream_result_count", 32'(n_out - base), 32'd8);

        // Randomized traffic with random back-pressure
        for (int n = 0; n < 400; n++) begin
            a = rand_val();
            case ($urandom_range(0, 9))
                0, 1:    b = a;
                2, 3:    b = a ^ 32'h80000000;
                4:       b = a + 32'd1;
                default: b = rand_val();
            endcase
            o = 3'($urandom_range(0, 7));
            model(o, a, b, er, ef);
            drive(($urandom % 5) != 0, o, a, b, ($urandom % 4) != 0, er, ef, 1'b0, acc);
        end
        drain();

        // Reset with two requests in flight
        send(3'd1, 32'h3F800000, 32'h40000000, 32'h00000001, 1'b0, 1'b0, 1'b0);
        send(3'd1, 32'h40000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rstn = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_res", res, 32'd0);
        chk("midreset_nv", 32'(nv), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        sbq.delete();
        repeat (2) @(negedge clk);
        #3 rstn = 1'b1;
        idle(4);
        send(3'd4, 32'hBF800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
